// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and constants for the multiply/divide unit
// Purpose : operation codes, FSM states and timing constants used by
//           mul_div_unit and by anything that must know its latency.
// Contents: MduWidth   default operand width
//           MduLatency start edge to HI/LO update edge, in cycles
//           mdu_op_e   3-bit operation code
//           state_e    IDLE/CALC/FIX control states
package mdu_pkg;

  localparam int MduWidth   = 32;
  localparam int MduLatency = MduWidth + 2;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/mdu_abs_neg.sv
// rtl/mdu_abs_neg.sv - conditional two's-complement negation
// Purpose : y_o = neg_i ? -a_i : a_i, modulo 2^Width. Used both for taking
//           operand magnitudes and for restoring result signs.
// Ports   : a_i   [Width] value
//           neg_i         negate when high
//           y_o   [Width] result
module mdu_abs_neg #(
  parameter int Width = 32
) (
  input  logic [Width-1:0] a_i,
  input  logic             neg_i,
  output logic [Width-1:0] y_o
);

  assign y_o = neg_i ? (~a_i + {{(Width-1){1'b0}}, 1'b1}) : a_i;

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - radix-2 iterative multiply/divide unit with HI/LO
// Purpose : MULT/MULTU/DIV/DIVU one bit per cycle, MTHI/MTLO direct writes.
// Ports   : clk_i, rst_i (async, active-high)
//           start_i, op_i[3], a_i[Width], b_i[Width]  request (sampled when idle)
//           busy_o   op in flight, starts ignored
//           done_o   one-cycle pulse, HI/LO already hold the new result
//           hi_o, lo_o [Width]  HI/LO registers
import mdu_pkg::*;

module mul_div_unit #(
  parameter int Width = MduWidth
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] hi_o,
  output logic [Width-1:0] lo_o
);

  localparam int              CntW    = $clog2(Width);
  localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);

  state_e             r_state, w_state_nxt;
  logic [CntW-1:0]    r_cnt;
  logic [2*Width-1:0] r_acc;    // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [Width-1:0]   r_opnd;   // multiplicand or divisor magnitude
  logic [Width-1:0]   r_hi, r_lo;
  logic               r_is_div, r_neg_a, r_neg_b, r_div0;
  logic               r_wr;     // result write stage: HI/LO load on the edge after FIX
  logic               r_done;

  logic               w_is_md, w_is_signed, w_is_div;
  logic               w_idle, w_accept;
  logic [Width-1:0]   w_abs_a, w_abs_b, w_quo, w_rem;
  logic [2*Width-1:0] w_prod, w_mul_next, w_div_next, w_acc_fix;
  logic [Width:0]     w_mul_sum, w_div_t, w_div_d;
  logic               w_div_ge;

  always_comb begin
    w_is_md     = 1'b0;
    w_is_signed = 1'b0;
    w_is_div    = 1'b0;
    case (op_i)
      OP_MULT:  begin w_is_md = 1'b1; w_is_signed = 1'b1; end
      OP_MULTU: begin w_is_md = 1'b1; end
      OP_DIV:   begin w_is_md = 1'b1; w_is_signed = 1'b1; w_is_div = 1'b1; end
      OP_DIVU:  begin w_is_md = 1'b1; w_is_div = 1'b1; end
      default:  ;
    endcase
  end

  // The write stage keeps busy_o high until HI/LO are loaded.
  assign w_idle   = (r_state == IDLE) && !r_wr;
  assign w_accept = w_idle && start_i && w_is_md;

  mdu_abs_neg #(.Width(Width)) u_abs_a (
    .a_i(a_i), .neg_i(w_is_signed & a_i[Width-1]), .y_o(w_abs_a));
  mdu_abs_neg #(.Width(Width)) u_abs_b (
    .a_i(b_i), .neg_i(w_is_signed & b_i[Width-1]), .y_o(w_abs_b));

  // Shift-add: add multiplicand into upper half when multiplier LSB set, shift right.
  assign w_mul_sum  = {1'b0, r_acc[2*Width-1:Width]} + {1'b0, (r_acc[0] ? r_opnd : {Width{1'b0}})};
  assign w_mul_next = {w_mul_sum, r_acc[Width-1:1]};

  // Restoring division; remainder < divisor keeps the trial difference within Width bits.
  assign w_div_t    = {r_acc[2*Width-1:Width], r_acc[Width-1]};
  assign w_div_d    = w_div_t - {1'b0, r_opnd};
  assign w_div_ge   = ~w_div_d[Width];
  assign w_div_next = {(w_div_ge ? w_div_d[Width-1:0] : w_div_t[Width-1:0]),
                       r_acc[Width-2:0], w_div_ge};

  mdu_abs_neg #(.Width(2*Width)) u_fix_prod (
    .a_i(r_acc), .neg_i(~r_is_div & (r_neg_a ^ r_neg_b)), .y_o(w_prod));
  mdu_abs_neg #(.Width(Width)) u_fix_quo (
    .a_i(r_acc[Width-1:0]), .neg_i(r_neg_a ^ r_neg_b), .y_o(w_quo));
  mdu_abs_neg #(.Width(Width)) u_fix_rem (
    .a_i(r_acc[2*Width-1:Width]), .neg_i(r_neg_a), .y_o(w_rem));

  // Divide by zero: remainder already equals the dividend; force quotient to all ones.
  always_comb begin
    w_acc_fix = w_prod;
    if (r_is_div) begin
      w_acc_fix = {w_rem, (r_div0 ? {Width{1'b1}} : w_quo)};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = CALC;
      CALC:    if (r_cnt == CntLast) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_div0   <= 1'b0;
      r_wr     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_wr   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt    <= '0;
            r_is_div <= w_is_div;
            r_neg_a  <= w_is_signed & a_i[Width-1];
            r_neg_b  <= w_is_signed & b_i[Width-1];
            r_div0   <= w_is_div && (b_i == '0);
            r_acc    <= {{Width{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
            r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
          end else if (w_idle && start_i && (op_i == OP_MTHI)) begin
            r_hi <= a_i;
          end else if (w_idle && start_i && (op_i == OP_MTLO)) begin
            r_lo <= a_i;
          end
        end
        CALC: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + CntW'(1);
        end
        FIX: begin
          r_acc <= w_acc_fix;
          r_wr  <= 1'b1;
        end
        default: ;
      endcase
      if (r_wr) begin
        r_hi   <= r_acc[2*Width-1:Width];
        r_lo   <= r_acc[Width-1:0];
        r_done <= 1'b1;
      end
    end
  end

  assign busy_o = (r_state != IDLE) || r_wr;
  assign done_o = r_done;
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          n_checks = 0;
  int          n_err = 0;
  int          n_done;

  mul_div_unit #(.Width(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge is the start edge.
  task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom(); b = $urandom();
  endtask

  // Entered n0 negedges after the start edge; returns at the first negedge with done high.
  task automatic wait_done(input string tag, input int n0,
                           input logic [31:0] old_hi, input logic [31:0] old_lo,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n = n0;
    check({tag, " busy"}, busy, 1);
    while (!done && n < 100) begin
      if (n == MduLatency - 1) begin
        check({tag, " old hi"}, hi, old_hi);
        check({tag, " old lo"}, lo, old_lo);
        check({tag, " busy late"}, busy, 1);
      end
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, MduLatency);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
    check({tag, " busy at done"}, busy, 0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    launch(o, x, y);
    wait_done(tag, 0, old_hi, old_lo, exp_hi, exp_lo);
    @(negedge clk);
    check({tag, " done pulse"}, done, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);

    run_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult", OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("divu", OP_DIVU, 32'd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFEB, 32'd1, 32'd3);
    run_op("div neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'd1, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0, 32'h80000000);
    run_op("divu by0", OP_DIVU, 32'd5, 32'd0, 32'h0, 32'h80000000, 32'd5, 32'hFFFFFFFF);
    run_op("div by0", OP_DIV, 32'hFFFFFFF9, 32'd0, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFF);

    launch(OP_MTHI, 32'h12345678, 32'd0);
    check("mthi hi", hi, 32'h12345678);
    check("mthi lo", lo, 32'hFFFFFFFF);
    check("mthi busy", busy, 0);
    check("mthi done", done, 0);
    @(negedge clk);
    check("mthi done later", done, 0);

    launch(3'd7, 32'hAAAA5555, 32'd1);
    check("bad op busy", busy, 0);
    check("bad op hi", hi, 32'h12345678);
    check("bad op lo", lo, 32'hFFFFFFFF);

    // Starts while busy must be dropped, MTLO included.
    launch(OP_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_MTLO; a = 32'hDEADBEEF;
    @(negedge clk);
    op = OP_MULTU; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    check("busy ign lo", lo, 32'hFFFFFFFF);
    wait_done("busy ign", 6, 32'h12345678, 32'hFFFFFFFF, 32'd2, 32'd14);

    // Back-to-back: start issued in the done cycle.
    launch(OP_DIVU, 32'd9, 32'd4);
    check("b2b done drop", done, 0);
    wait_done("b2b", 0, 32'd2, 32'd14, 32'd1, 32'd2);
    @(negedge clk);

    // Asynchronous reset in the middle of CALC.
    launch(OP_MULTU, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst mid busy", busy, 0);
    check("rst mid hi", hi, 0);
    check("rst mid lo", lo, 0);
    check("rst mid done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("rst no done", n_done, 0);
    check("rst idle busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
